serial_bus_master: RTL

Initiator side of the single-wire-per-direction serial bus: accepts one read or write request from a parallel host port and serialises it to a bus slave. Sequence: start bit, wait for slave ready, 12-bit address and mode bit out, then 8 data bits out (write) or in (read). It sits between a host or arbiter and the slave's `rx`/`tx` pair, one master per slave link.

---
 rtl/serial_bus_master.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_bus_master.sv
// serial_bus_master: initiator for the single-wire-per-direction serial bus
`timescale 1ns/1ps
module serial_bus_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int ALIGN_CYC  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  active_o,
    output logic                  tx_o,
    input  logic                  rx_i
);
    localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + ALIGN_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, ALIGN, ADDR, WDATA, RGAP, RDATA} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    assign ready_o  = (state_q == IDLE) && rx_i;
    assign active_o = (state_q != IDLE);
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign tx_o     = tx_q;

    // Next state: address and write data are shifted out of their capture registers LSB first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (req_i && ready_o) begin
                wr_d    = wr_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: if (!rx_i) begin
                cnt_d   = '0;
                state_d = ALIGN;
            end
            ALIGN: if (cnt_q == CW'(ALIGN_CYC - 1)) begin
                tx_d    = addr_q[0];
                addr_d  = addr_q >> 1;
                cnt_d   = CW'(1);
                state_d = ADDR;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            ADDR: if (cnt_q == CW'(ADDR_WIDTH)) begin
                tx_d    = wr_q;
                cnt_d   = '0;
                state_d = wr_q ? WDATA : RGAP;
            end else begin
                tx_d   = addr_q[0];
                addr_d = addr_q >> 1;
                cnt_d  = cnt_q + CW'(1);
            end
            WDATA: if (cnt_q == CW'(DATA_WIDTH)) begin
                tx_d    = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                tx_d    = wdata_q[0];
                wdata_d = wdata_q >> 1;
                cnt_d   = cnt_q + CW'(1);
            end
            RGAP: begin
                tx_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RDATA: begin
                shift_d = {rx_i, shift_q[DATA_WIDTH-1:1]};
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    rdata_d = shift_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
        end
    end
endmodule
